// File: rtl/bram_snapshot_ctrl.sv
// Snapshot capture controller: arms, waits for a trigger, then streams valid samples into a BRAM write port.
// Optional macro SNAPSHOT_PRETRIG_EN keeps writing a circular pre-trigger history while armed.
module bram_snapshot_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  fpga_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   capture_len,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [ADDR_WIDTH-1:0] trig_addr
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     wr_count_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic                    bram_we_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic [DATA_WIDTH-1:0]   bram_din_q;

  logic [ADDR_WIDTH:0]     len_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [ADDR_WIDTH:0]     wr_count_d;
  logic                    last_d;

  // Zero and oversize lengths both mean "fill the whole BRAM".
  always_comb begin
    len_d      = capture_len;
    if (capture_len == '0 || capture_len > DEPTH_C) len_d = DEPTH_C;
    addr_d     = addr_q + 1'b1;
    wr_count_d = wr_count_q + ONE_C;
    last_d     = (wr_count_d == len_q);
  end

`ifdef SNAPSHOT_PRETRIG_EN
  logic [ADDR_WIDTH-1:0] trig_addr_q;
`endif

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_count_q  <= '0;
      len_q       <= DEPTH_C;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
`ifdef SNAPSHOT_PRETRIG_EN
      trig_addr_q <= '0;
`endif
    end else begin
      bram_we_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state_q    <= S_ARMED;
              len_q      <= len_d;
              wr_count_q <= '0;
              addr_q     <= '0;
`ifdef SNAPSHOT_PRETRIG_EN
              trig_addr_q <= '0;
`endif
            end
          end
          S_ARMED: begin
            if (trigger) begin
`ifdef SNAPSHOT_PRETRIG_EN
              trig_addr_q <= addr_q;
`endif
              // The trigger-cycle sample is the first post-trigger sample.
              if (din_valid) begin
                bram_we_q   <= 1'b1;
                bram_addr_q <= addr_q;
                bram_din_q  <= din;
                addr_q      <= addr_d;
                wr_count_q  <= ONE_C;
                state_q     <= (len_q == ONE_C) ? S_DONE : S_CAPTURE;
              end else begin
                wr_count_q  <= '0;
                state_q     <= S_CAPTURE;
              end
            end
`ifdef SNAPSHOT_PRETRIG_EN
            else if (din_valid) begin
              bram_we_q   <= 1'b1;
              bram_addr_q <= addr_q;
              bram_din_q  <= din;
              addr_q      <= addr_d;
              if (wr_count_q != DEPTH_C) wr_count_q <= wr_count_d;
            end
`endif
          end
          S_CAPTURE: begin
            if (din_valid) begin
              bram_we_q   <= 1'b1;
              bram_addr_q <= addr_q;
              bram_din_q  <= din;
              addr_q      <= addr_d;
              wr_count_q  <= wr_count_d;
              if (last_d) state_q <= S_DONE;
            end
          end
        endcase
      end
    end
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign wr_count  = wr_count_q;
  assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
`ifdef SNAPSHOT_PRETRIG_EN
  assign trig_addr = trig_addr_q;
`else
  assign trig_addr = '0;
`endif

endmodule

// File: tb/tb_bram_snapshot_ctrl.sv
// Scoreboard bench for bram_snapshot_ctrl (ADDR_WIDTH=4): stimulus queues expected writes, a monitor checks them.
module tb_bram_snapshot_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   capture_len = '0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic [AW-1:0] trig_addr;

  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_q[$];

  bram_snapshot_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .fpga_clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .arm(arm),
    .trigger(trigger), .abort(abort), .capture_len(capture_len),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .busy(busy), .done(done), .wr_count(wr_count), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required none", bram_addr, bram_din);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({bram_addr, bram_din} !== e) begin
          failures++;
          $display("FAIL write actual addr=%0h data=%0h required addr=%0h data=%0h",
                   bram_addr, bram_din, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic trg, input logic [DW-1:0] d,
                       input logic exp_wr, input logic [AW-1:0] a);
    din_valid = v;
    trigger   = trg;
    din       = d;
    if (exp_wr) exp_q.push_back({a, d});
    step();
    din_valid = 1'b0;
    trigger   = 1'b0;
  endtask

  task automatic do_arm(input logic [AW:0] len);
    arm = 1'b1;
    capture_len = len;
    step();
    arm = 1'b0;
  endtask

  task automatic drain(input string name);
    step();
    step();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_wr_count", wr_count, 0);
    rst = 1'b0;
    step();

    // Basic capture of 4, arm during capture ignored, trigger in DONE ignored
    do_arm(5'd4);
    chk("armed_busy", {busy, done}, 2'b10);
    drive(1, 1, 16'hA0, 1, 0);
    drive(1, 0, 16'hA1, 1, 1);
    arm = 1'b1;
    drive(1, 0, 16'hA2, 1, 2);
    arm = 1'b0;
    chk("arm_ignored_count", wr_count, 3);
    drive(1, 0, 16'hA3, 1, 3);
    chk("basic_done", {busy, done}, 2'b01);
    chk("basic_wr_count", wr_count, 4);
    drive(1, 0, 16'hA4, 0, 0);
    drive(1, 1, 16'hA5, 0, 0);
    chk("done_hold_count", wr_count, 4);
    chk("done_hold_state", {busy, done}, 2'b01);
    drain("basic_queue");

    // Gaps: valid pattern 1,0,1,0,1 from the trigger cycle
    do_arm(5'd3);
    chk("rearm_clears_count", wr_count, 0);
    drive(1, 1, 16'hB0, 1, 0);
    drive(0, 0, 16'hB1, 0, 0);
    drive(1, 0, 16'hB2, 1, 1);
    drive(0, 0, 16'hB3, 0, 0);
    chk("gaps_not_done", done, 0);
    drive(1, 0, 16'hB4, 1, 2);
    chk("gaps_done", done, 1);
    chk("gaps_wr_count", wr_count, 3);
    drain("gaps_queue");

    // Clamp: length 0 fills all 16 entries
    do_arm(5'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1, (i == 0), DW'(16'h100 + i), 1, AW'(i));
      if (i == 14) chk("clamp_busy_at_15", {busy, done}, 2'b10);
    end
    chk("clamp_done", done, 1);
    chk("clamp_wr_count", wr_count, 16);
    drive(1, 0, 16'h1FF, 0, 0);
    drain("clamp_queue");

    // Abort after 2 of 8, arm in the same cycle
    do_arm(5'd8);
    drive(1, 1, 16'hC0, 1, 0);
    drive(1, 0, 16'hC1, 1, 1);
    abort = 1'b1;
    arm = 1'b1;
    drive(1, 0, 16'hC2, 0, 0);
    abort = 1'b0;
    arm = 1'b0;
    chk("abort_idle", {busy, done}, 2'b00);
    chk("abort_wr_count", wr_count, 2);
    drive(1, 1, 16'hC3, 0, 0);
    drive(1, 0, 16'hC4, 0, 0);
    chk("idle_trigger_ignored", {busy, done}, 2'b00);
    drain("abort_queue");

    // Reset in the middle of a capture
    do_arm(5'd8);
    drive(1, 1, 16'hD0, 1, 0);
    for (int i = 1; i < 5; i++) drive(1, 0, DW'(16'hD0 + i), 1, AW'(i));
    drive(0, 0, 16'h0, 0, 0);
    chk("pre_rst_count", wr_count, 5);
    din_valid = 1'b1;
    din = 16'hDD;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {bram_we, bram_addr, bram_din, trig_addr}, 0);
    chk("rst_mid_status", {busy, done, wr_count}, 0);
    step();
    step();
    rst = 1'b0;
    drive(1, 0, 16'hDE, 0, 0);
    drive(1, 0, 16'hDF, 0, 0);
    chk("post_rst_idle", {busy, done}, 2'b00);
    drain("rst_queue");

    // 20 samples while armed, then trigger with length 4
    do_arm(5'd4);
    for (int i = 0; i < 20; i++) begin
`ifdef SNAPSHOT_PRETRIG_EN
      drive(1, 0, DW'(16'h200 + i), 1, AW'(i));
`else
      drive(1, 0, DW'(16'h200 + i), 0, 0);
`endif
    end
`ifdef SNAPSHOT_PRETRIG_EN
    chk("pretrig_sat_count", wr_count, 16);
    drive(1, 1, 16'h300, 1, 4);
    chk("trig_addr", trig_addr, 4);
    for (int i = 1; i < 4; i++) drive(1, 0, DW'(16'h300 + i), 1, AW'(4 + i));
`else
    chk("armed_no_count", wr_count, 0);
    drive(1, 1, 16'h300, 1, 0);
    chk("trig_addr_zero", trig_addr, 0);
    for (int i = 1; i < 4; i++) drive(1, 0, DW'(16'h300 + i), 1, AW'(i));
`endif
    chk("trig_done", done, 1);
    chk("trig_wr_count", wr_count, 4);
    drain("trig_queue");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
